me_load_ctrl: RTL and testbench

//  Parametrised loader/sequencer in front of the motion-estimation engine. Accepts pixel-serial

---
 rtl/me_load_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_me_load_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : me_load_ctrl (with helper me_load_chan)
//  Purpose  : Loader/sequencer in front of the motion-estimation engine.
//             Packs pixel-serial cur/ref streams into buffer words and writes
//             them linearly, then runs the go/done handshake and counts
//             blocks. Can reuse the previous reference window between blocks.
//  Revision : 1.0 - initial release
// ============================================================================

// One loader channel: accepts pixels, packs them LSB-first into words and
// emits a single-cycle write per completed word at a linear address.
module me_load_chan #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int WORDS        = 32,
  parameter int AW           = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          enable,
  input  logic                          valid,
  input  logic [PIX_W-1:0]              pixel,
  output logic                          ready,
  output logic                          we,
  output logic [AW-1:0]                 addr,
  output logic [PIX_W*PIX_PER_WORD-1:0] data,
  output logic                          complete
);
  localparam int DW     = PIX_W * PIX_PER_WORD;
  localparam int PIXELS = WORDS * PIX_PER_WORD;
  localparam int PCW    = $clog2(PIXELS + 1);
  localparam int SW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int CNTW   = AW + 1;

  logic [PCW-1:0]  pix_cnt;
  logic [PCW-1:0]  pix_cnt_nxt;
  logic [SW-1:0]   slot;
  logic [CNTW-1:0] word_cnt;
  logic [DW-1:0]   pack;
  logic [DW-1:0]   word;
  logic            accept;
  logic            word_end;

  assign accept      = valid & ready;
  assign word_end    = accept && (slot == SW'(PIX_PER_WORD - 1));
  assign pix_cnt_nxt = pix_cnt + PCW'(accept);
  assign complete    = (word_cnt == CNTW'(WORDS));

  // Completed word: partial pack with the final pixel dropped into the top slot
  always_comb begin
    word = pack;
    word[(PIX_PER_WORD-1)*PIX_W +: PIX_W] = pixel;
  end

  // Pixel acceptance, packing, word write and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      slot     <= '0;
      word_cnt <= '0;
      pack     <= '0;
      ready    <= 1'b0;
      we       <= 1'b0;
      addr     <= '0;
      data     <= '0;
    end else begin
      we <= 1'b0;
      if (clear) begin
        pix_cnt  <= '0;
        slot     <= '0;
        word_cnt <= '0;
        pack     <= '0;
        ready    <= 1'b0;
      end else begin
        if (accept) begin
          pix_cnt <= pix_cnt_nxt;
          pack[slot*PIX_W +: PIX_W] <= pixel;
          if (word_end) begin
            slot     <= '0;
            we       <= 1'b1;
            addr     <= word_cnt[AW-1:0];
            data     <= word;
            word_cnt <= word_cnt + CNTW'(1);
          end else begin
            slot <= slot + SW'(1);
          end
        end
        // Drop ready on the edge that takes the last pixel so none is over-accepted
        ready <= enable && (pix_cnt_nxt < PCW'(PIXELS));
      end
    end
  end
endmodule

module me_load_ctrl #(
  parameter int  PIX_W        = 8,
  parameter int  PIX_PER_WORD = 8,
  parameter int  CUR_DIM      = 16,
  parameter int  REF_DIM      = 32,
  localparam int DW           = PIX_W * PIX_PER_WORD,
  localparam int CUR_WORDS    = CUR_DIM * CUR_DIM / PIX_PER_WORD,
  localparam int REF_WORDS    = REF_DIM * REF_DIM / PIX_PER_WORD,
  localparam int CUR_AW       = $clog2(CUR_WORDS),
  localparam int REF_AW       = $clog2(REF_WORDS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cur_valid,
  input  logic [PIX_W-1:0]  cur_data,
  output logic              cur_ready,
  input  logic              ref_valid,
  input  logic [PIX_W-1:0]  ref_data,
  output logic              ref_ready,
  input  logic [1:0]        r_in,
  input  logic              ref_reuse,
  output logic [CUR_AW-1:0] addr_cur,
  output logic [DW-1:0]     data_cur,
  output logic              we_cur,
  output logic [REF_AW-1:0] addr_ref,
  output logic [DW-1:0]     data_ref,
  output logic              we_ref,
  output logic [1:0]        r,
  output logic              go,
  input  logic              done,
  output logic [15:0]       blk_cnt
);
  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0] state;
  logic       skip_ref;
  logic       ref_valid_flag;
  logic       cur_complete;
  logic       ref_complete;
  logic       load_done;
  logic       chan_clear;
  logic       cur_enable;
  logic       ref_enable;

  assign chan_clear = (state == ST_START);
  assign cur_enable = (state == ST_LOAD);
  assign ref_enable = (state == ST_LOAD) && !skip_ref;
  assign load_done  = cur_complete && (skip_ref || ref_complete);

  me_load_chan #(
    .PIX_W        (PIX_W),
    .PIX_PER_WORD (PIX_PER_WORD),
    .WORDS        (CUR_WORDS),
    .AW           (CUR_AW)
  ) u_cur (
    .clk      (clk),
    .rst_n    (reset_n),
    .clear    (chan_clear),
    .enable   (cur_enable),
    .valid    (cur_valid),
    .pixel    (cur_data),
    .ready    (cur_ready),
    .we       (we_cur),
    .addr     (addr_cur),
    .data     (data_cur),
    .complete (cur_complete)
  );

  me_load_chan #(
    .PIX_W        (PIX_W),
    .PIX_PER_WORD (PIX_PER_WORD),
    .WORDS        (REF_WORDS),
    .AW           (REF_AW)
  ) u_ref (
    .clk      (clk),
    .rst_n    (reset_n),
    .clear    (chan_clear),
    .enable   (ref_enable),
    .valid    (ref_valid),
    .pixel    (ref_data),
    .ready    (ref_ready),
    .we       (we_ref),
    .addr     (addr_ref),
    .data     (data_ref),
    .complete (ref_complete)
  );

  // Block sequencer: START latches block config, LOAD fills buffers, RUN handshakes with the engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_START;
      go             <= 1'b0;
      r              <= 2'd0;
      blk_cnt        <= 16'd0;
      skip_ref       <= 1'b0;
      ref_valid_flag <= 1'b0;
    end else begin
      // A window is reusable only once one has been fully loaded since reset
      if (ref_complete) begin
        ref_valid_flag <= 1'b1;
      end
      case (state)
        ST_START: begin
          r        <= r_in;
          skip_ref <= ref_reuse & ref_valid_flag;
          state    <= ST_LOAD;
        end
        ST_LOAD: begin
          // A done left high by the previous block holds off the next go
          if (load_done && !done) begin
            go    <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (done) begin
            go      <= 1'b0;
            blk_cnt <= blk_cnt + 16'd1;
            state   <= ST_START;
          end
        end
        default: begin
          state <= ST_START;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_me_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_me_load_ctrl
//  Purpose  : Self-checking bench for me_load_ctrl. Streams pixels with
//             optional random gaps and compares buffer writes against words
//             built from the pixel arrays, plus go/done/reuse/reset behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_me_load_ctrl;
  localparam int PIX_W     = 8;
  localparam int PPW       = 8;
  localparam int CUR_DIM   = 16;
  localparam int REF_DIM   = 32;
  localparam int DW        = PIX_W * PPW;
  localparam int CUR_WORDS = CUR_DIM * CUR_DIM / PPW;
  localparam int REF_WORDS = REF_DIM * REF_DIM / PPW;
  localparam int CUR_AW    = $clog2(CUR_WORDS);
  localparam int REF_AW    = $clog2(REF_WORDS);
  localparam int CUR_PIX   = CUR_DIM * CUR_DIM;
  localparam int REF_PIX   = REF_DIM * REF_DIM;

  logic              clk;
  logic              reset_n;
  logic              cur_valid;
  logic [PIX_W-1:0]  cur_data;
  logic              cur_ready;
  logic              ref_valid;
  logic [PIX_W-1:0]  ref_data;
  logic              ref_ready;
  logic [1:0]        r_in;
  logic              ref_reuse;
  logic [CUR_AW-1:0] addr_cur;
  logic [DW-1:0]     data_cur;
  logic              we_cur;
  logic [REF_AW-1:0] addr_ref;
  logic [DW-1:0]     data_ref;
  logic              we_ref;
  logic [1:0]        r;
  logic              go;
  logic              done;
  logic [15:0]       blk_cnt;

  me_load_ctrl #(
    .PIX_W (PIX_W), .PIX_PER_WORD (PPW), .CUR_DIM (CUR_DIM), .REF_DIM (REF_DIM)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .cur_valid (cur_valid), .cur_data (cur_data), .cur_ready (cur_ready),
    .ref_valid (ref_valid), .ref_data (ref_data), .ref_ready (ref_ready),
    .r_in (r_in), .ref_reuse (ref_reuse),
    .addr_cur (addr_cur), .data_cur (data_cur), .we_cur (we_cur),
    .addr_ref (addr_ref), .data_ref (data_ref), .we_ref (we_ref),
    .r (r), .go (go), .done (done), .blk_cnt (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Pixel sources and the block contents the model expects
  logic [7:0] cur_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] blk_cur [CUR_PIX];
  logic [7:0] blk_ref [REF_PIX];
  int gap_pct = 0;
  int cur_acc = 0;
  int ref_acc = 0;

  // Observed writes and handshake timing
  int         cur_wa[$];
  logic [DW-1:0] cur_wd[$];
  int         ref_wa[$];
  logic [DW-1:0] ref_wd[$];
  int cyc = 0;
  int last_we = -1;
  int go_rise = -1;
  bit go_prev = 0;
  bit ref_ready_seen = 0;

  // Expected buffer word: pixel k of the word lands in byte k
  function automatic logic [DW-1:0] exp_word(input bit is_ref, input int j);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < PPW; k++)
      w[k*PIX_W +: PIX_W] = is_ref ? blk_ref[j*PPW+k] : blk_cur[j*PPW+k];
    return w;
  endfunction

  // Cur source: a pixel leaves the queue only when the previous edge accepted it
  initial begin : cur_drv
    bit pend;
    pend = 0;
    cur_valid = 1'b0;
    cur_data  = '0;
    forever begin
      @(negedge clk);
      if (pend && reset_n) begin
        void'(cur_q.pop_front());
        cur_acc++;
      end
      if (cur_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        cur_valid = 1'b1;
        cur_data  = cur_q[0];
      end else begin
        cur_valid = 1'b0;
        cur_data  = 8'($urandom);
      end
      pend = cur_valid && cur_ready;
    end
  end

  // Ref source, same acceptance bookkeeping as the cur source
  initial begin : ref_drv
    bit pend;
    pend = 0;
    ref_valid = 1'b0;
    ref_data  = '0;
    forever begin
      @(negedge clk);
      if (pend && reset_n) begin
        void'(ref_q.pop_front());
        ref_acc++;
      end
      if (ref_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        ref_valid = 1'b1;
        ref_data  = ref_q[0];
      end else begin
        ref_valid = 1'b0;
        ref_data  = 8'($urandom);
      end
      pend = ref_valid && ref_ready;
    end
  end

  // Write and go monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (we_cur) begin
      cur_wa.push_back(int'(addr_cur));
      cur_wd.push_back(data_cur);
      last_we = cyc;
    end
    if (we_ref) begin
      ref_wa.push_back(int'(addr_ref));
      ref_wd.push_back(data_ref);
      last_we = cyc;
    end
    if (go && !go_prev) go_rise = cyc;
    go_prev = go;
    if (ref_ready) ref_ready_seen = 1'b1;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    cur_wa.delete(); cur_wd.delete(); ref_wa.delete(); ref_wd.delete();
    last_we = -1; go_rise = -1; ref_ready_seen = 1'b0;
  endtask

  task automatic fill_block(input bit cur_rand, input bit ref_rand, input bit load_ref);
    for (int i = 0; i < CUR_PIX; i++) begin
      blk_cur[i] = cur_rand ? 8'($urandom) : 8'(i);
      cur_q.push_back(blk_cur[i]);
    end
    if (load_ref) begin
      for (int i = 0; i < REF_PIX; i++) begin
        blk_ref[i] = ref_rand ? 8'($urandom) : 8'(i * 3);
        ref_q.push_back(blk_ref[i]);
      end
    end
  endtask

  task automatic wait_go(input int limit, output bit ok);
    ok = 0;
    for (int n = 0; n < limit && !ok; n++) begin
      @(negedge clk);
      if (go) ok = 1;
    end
    #1;
  endtask

  task automatic pulse_done(input int n);
    done = 1'b1;
    repeat (n) @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_reset();
    logic [255:0] outs;
    reset_n = 1'b0; r_in = 2'd3; ref_reuse = 1'b0; done = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    fill_block(1'b0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    checks++;
    if (cur_wa.size() == 0) $display("FAIL midload_progress: cur writes %0d, need >0", cur_wa.size());
    else passed++;
    #1 reset_n = 1'b0;
    #1;
    outs = 256'({cur_ready, ref_ready, we_cur, we_ref, go, r, blk_cnt,
                 addr_cur, addr_ref, data_cur, data_ref});
    checks++;
    if (outs !== '0) $display("FAIL async_reset_outputs: got %h, want 0", outs);
    else passed++;
    cur_q.delete(); ref_q.delete(); clear_mon();
    r_in = 2'd2;
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cur_ready, ref_ready} !== 2'b00) $display("FAIL ready_cycle1: got %b, want 00", {cur_ready, ref_ready});
    else passed++;
    @(negedge clk);
    checks++;
    if ({cur_ready, ref_ready} !== 2'b11) $display("FAIL ready_cycle2: got %b, want 11", {cur_ready, ref_ready});
    else passed++;
  endtask

  task automatic test_full_load();
    bit ok;
    clear_mon(); gap_pct = 0;
    fill_block(1'b0, 1'b0, 1'b1);
    wait_go(3000, ok);
    checks++;
    if (!ok) $display("FAIL t2_go_timeout: go=%b, want 1", go); else passed++;
    checks++;
    if (cur_wa.size() != CUR_WORDS) $display("FAIL t2_cur_count: got %0d, want %0d", cur_wa.size(), CUR_WORDS);
    else passed++;
    for (int j = 0; j < CUR_WORDS && j < cur_wa.size(); j++) begin
      checks++;
      if (cur_wa[j] != j || cur_wd[j] !== exp_word(1'b0, j))
        $display("FAIL t2_cur_word%0d: got a=%0d d=%h, want a=%0d d=%h", j, cur_wa[j], cur_wd[j], j, exp_word(1'b0, j));
      else passed++;
    end
    checks++;
    if (cur_wd.size() == 0 || cur_wd[0] !== 64'h0706050403020100)
      $display("FAIL t2_first_data: got %h, want 0706050403020100", (cur_wd.size() > 0) ? cur_wd[0] : '0);
    else passed++;
    checks++;
    if (ref_wa.size() != REF_WORDS) $display("FAIL t2_ref_count: got %0d, want %0d", ref_wa.size(), REF_WORDS);
    else passed++;
    for (int j = 0; j < REF_WORDS && j < ref_wa.size(); j++) begin
      checks++;
      if (ref_wa[j] != j || ref_wd[j] !== exp_word(1'b1, j))
        $display("FAIL t2_ref_word%0d: got a=%0d d=%h, want a=%0d d=%h", j, ref_wa[j], ref_wd[j], j, exp_word(1'b1, j));
      else passed++;
    end
    checks++;
    if (go_rise != last_we + 1) $display("FAIL t2_go_timing: go rise cycle %0d, want %0d", go_rise, last_we + 1);
    else passed++;
    checks++;
    if (r !== 2'd2) $display("FAIL t2_r: got %0d, want 2", r); else passed++;
  endtask

  task automatic test_done_handshake();
    repeat (3) @(negedge clk);
    checks++;
    if (go !== 1'b1) $display("FAIL t4_go_level: got %b, want 1", go); else passed++;
    r_in = 2'd1; ref_reuse = 1'b0;
    done = 1'b1;
    @(negedge clk);
    checks++;
    if (go !== 1'b0 || blk_cnt !== 16'd1)
      $display("FAIL t4_done_response: got go=%b blk_cnt=%0d, want go=0 blk_cnt=1", go, blk_cnt);
    else passed++;
    repeat (4) @(negedge clk);
    done = 1'b0;
  endtask

  task automatic test_gaps();
    bit ok;
    clear_mon(); gap_pct = 40;
    fill_block(1'b0, 1'b0, 1'b1);
    wait_go(6000, ok);
    checks++;
    if (!ok) $display("FAIL t3_go_timeout: go=%b, want 1", go); else passed++;
    checks++;
    if (cur_wa.size() != CUR_WORDS || ref_wa.size() != REF_WORDS)
      $display("FAIL t3_counts: got cur=%0d ref=%0d, want %0d/%0d", cur_wa.size(), ref_wa.size(), CUR_WORDS, REF_WORDS);
    else passed++;
    for (int j = 0; j < CUR_WORDS && j < cur_wa.size(); j++) begin
      checks++;
      if (cur_wa[j] != j || cur_wd[j] !== exp_word(1'b0, j))
        $display("FAIL t3_cur_word%0d: got a=%0d d=%h, want a=%0d d=%h", j, cur_wa[j], cur_wd[j], j, exp_word(1'b0, j));
      else passed++;
    end
    for (int j = 0; j < REF_WORDS && j < ref_wa.size(); j++) begin
      checks++;
      if (ref_wa[j] != j || ref_wd[j] !== exp_word(1'b1, j))
        $display("FAIL t3_ref_word%0d: got a=%0d d=%h, want a=%0d d=%h", j, ref_wa[j], ref_wd[j], j, exp_word(1'b1, j));
      else passed++;
    end
    checks++;
    if (r !== 2'd1) $display("FAIL t3_r: got %0d, want 1", r); else passed++;
    gap_pct = 0;
  endtask

  task automatic test_reuse_withheld();
    bit go_high;
    ref_reuse = 1'b1; r_in = 2'd3;
    done = 1'b1;
    @(negedge clk);
    checks++;
    if (go !== 1'b0 || blk_cnt !== 16'd2)
      $display("FAIL t5_blk2_done: got go=%b blk_cnt=%0d, want go=0 blk_cnt=2", go, blk_cnt);
    else passed++;
    clear_mon();
    fill_block(1'b1, 1'b0, 1'b0);
    go_high = 0;
    repeat (400) begin
      @(negedge clk);
      if (go) go_high = 1;
    end
    checks++;
    if (go_high) $display("FAIL t4_go_withheld: go rose while done high, want 0"); else passed++;
    checks++;
    if (cur_wa.size() != CUR_WORDS) $display("FAIL t5_cur_count: got %0d, want %0d", cur_wa.size(), CUR_WORDS);
    else passed++;
    done = 1'b0;
    @(negedge clk);
    checks++;
    if (go !== 1'b1) $display("FAIL t4_go_after_done_low: got %b, want 1", go); else passed++;
    checks++;
    if (ref_wa.size() != 0 || ref_ready_seen)
      $display("FAIL t5_ref_skipped: got ref writes %0d ready_seen %b, want 0 0", ref_wa.size(), ref_ready_seen);
    else passed++;
    for (int j = 0; j < CUR_WORDS && j < cur_wa.size(); j++) begin
      checks++;
      if (cur_wa[j] != j || cur_wd[j] !== exp_word(1'b0, j))
        $display("FAIL t5_cur_word%0d: got a=%0d d=%h, want a=%0d d=%h", j, cur_wa[j], cur_wd[j], j, exp_word(1'b0, j));
      else passed++;
    end
    checks++;
    if (r !== 2'd3) $display("FAIL t5_r: got %0d, want 3", r); else passed++;
    pulse_done(1);
    checks++;
    if (blk_cnt !== 16'd3) $display("FAIL t5_blk_cnt: got %0d, want 3", blk_cnt); else passed++;
  endtask

  task automatic test_reset_midload();
    logic [7:0]    stream[$];
    logic [DW-1:0] w;
    int start;
    bit ok;
    // ref_reuse stays 1: the window is valid, so this block skips ref until reset clears that
    for (int i = 0; i < CUR_PIX + 100; i++) stream.push_back(8'($urandom));
    start = cur_acc;
    foreach (stream[i]) cur_q.push_back(stream[i]);
    for (int n = 0; n < 20000 && cur_acc < start + 100; n++) #1;
    reset_n = 1'b0;
    checks++;
    if (cur_acc != start + 100) $display("FAIL t6_pre_count: got %0d pixels, want 100", cur_acc - start);
    else passed++;
    clear_mon();
    repeat (2) @(negedge clk);
    for (int i = 0; i < CUR_PIX; i++) blk_cur[i] = stream[100+i];
    for (int i = 0; i < REF_PIX; i++) begin
      blk_ref[i] = 8'($urandom);
      ref_q.push_back(blk_ref[i]);
    end
    #1 reset_n = 1'b1;
    wait_go(3000, ok);
    checks++;
    if (!ok) $display("FAIL t6_go_timeout: go=%b, want 1", go); else passed++;
    w = '0;
    for (int k = 0; k < PPW; k++) w[k*PIX_W +: PIX_W] = stream[100+k];
    checks++;
    if (cur_wa.size() == 0 || cur_wa[0] != 0 || cur_wd[0] !== w)
      $display("FAIL t6_first_word: got n=%0d d=%h, want a=0 d=%h", cur_wa.size(), (cur_wd.size() > 0) ? cur_wd[0] : '0, w);
    else passed++;
    checks++;
    if (cur_wa.size() != CUR_WORDS || ref_wa.size() != REF_WORDS)
      $display("FAIL t6_counts: got cur=%0d ref=%0d, want %0d/%0d", cur_wa.size(), ref_wa.size(), CUR_WORDS, REF_WORDS);
    else passed++;
    for (int j = 0; j < REF_WORDS && j < ref_wa.size(); j++) begin
      checks++;
      if (ref_wa[j] != j || ref_wd[j] !== exp_word(1'b1, j))
        $display("FAIL t6_ref_word%0d: got a=%0d d=%h, want a=%0d d=%h", j, ref_wa[j], ref_wd[j], j, exp_word(1'b1, j));
      else passed++;
    end
    pulse_done(1);
    checks++;
    if (blk_cnt !== 16'd1) $display("FAIL t6_blk_cnt: got %0d, want 1", blk_cnt); else passed++;
    cur_q.delete(); ref_q.delete();
  endtask

  initial begin : main
    reset_n = 1'b0; r_in = 2'd0; ref_reuse = 1'b0; done = 1'b0;
    test_reset();
    test_full_load();
    test_done_handshake();
    test_gaps();
    test_reuse_withheld();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
